// File: rtl/universal_shift_reg.sv
// Parametrised universal register: hold, load, shift, rotate and count up/down,
// with serial ports at both ends, a zero flag and a one-cycle carry/borrow pulse.
module universal_shift_reg #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic             carry
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;
  logic             carry_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             carry_nxt_s;

  // Next-state selection: clear beats enable beats mode; unknown modes hold.
  always_comb begin
    q_nxt_s     = q_r;
    carry_nxt_s = 1'b0;
    if (clr) begin
      q_nxt_s = ZERO_C;
    end else if (!en) begin
      q_nxt_s = q_r;
    end else begin
      case (mode)
        MODE_HOLD: q_nxt_s = q_r;
        MODE_LOAD: q_nxt_s = d;
        MODE_SHL:  q_nxt_s = {q_r[WIDTH-2:0], sin_r};
        MODE_SHR:  q_nxt_s = {sin_l, q_r[WIDTH-1:1]};
        MODE_ROL:  q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        MODE_ROR:  q_nxt_s = {q_r[0], q_r[WIDTH-1:1]};
        MODE_INC: begin
          q_nxt_s     = q_r + ONE_C;
          carry_nxt_s = &q_r;
        end
        MODE_DEC: begin
          q_nxt_s     = q_r - ONE_C;
          carry_nxt_s = ~|q_r;
        end
        default:   q_nxt_s = q_r;
      endcase
    end
  end

  // State register; carry is rewritten every edge so it never sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= RESET_VAL;
      carry_r <= 1'b0;
    end else begin
      q_r     <= q_nxt_s;
      carry_r <= carry_nxt_s;
    end
  end

  assign q      = q_r;
  assign carry  = carry_r;
  assign sout_l = q_r[WIDTH-1];
  assign sout_r = q_r[0];
  assign zero   = (q_r == ZERO_C);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (4-bit default and an
// 8-bit instance with a non-zero reset value).
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [3:0] d;
  logic [3:0] q;
  logic       sout_l, sout_r, zero, carry;

  logic       clr8, en8;
  logic [2:0] mode8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic       sout_l8, sout_r8, zero8, carry8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l), .sout_r(sout_r),
    .zero(zero), .carry(carry)
  );

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .en(en8), .mode(mode8), .d(d8),
    .sin_l(1'b0), .sin_r(1'b0), .q(q8), .sout_l(sout_l8), .sout_r(sout_r8),
    .zero(zero8), .carry(carry8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq, input logic ez, input logic ec);
    chk({tag, " q"}, {4'h0, q}, {4'h0, eq});
    chk({tag, " zero"}, {7'h0, zero}, {7'h0, ez});
    chk({tag, " carry"}, {7'h0, carry}, {7'h0, ec});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; mode = 3'b000; d = 4'b0000;
    sin_l = 1'b0; sin_r = 1'b0;
    clr8 = 1'b0; en8 = 1'b0; mode8 = 3'b000; d8 = 8'h00;
    step();
    step();
    chk4("reset", 4'b0000, 1'b1, 1'b0);
    chk("reset8 q", q8, 8'hA5);
    chk("reset8 carry", {7'h0, carry8}, 8'h00);
    rst_n = 1'b1;

    // Async reset between edges
    en = 1'b1; mode = 3'b001; d = 4'b1010;
    step();
    chk4("load 1010", 4'b1010, 1'b0, 1'b0);
    en = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk4("async reset", 4'b0000, 1'b1, 1'b0);
    step();
    rst_n = 1'b1;

    // Load / hold
    en = 1'b1; mode = 3'b001; d = 4'b1111;
    step();
    chk4("load 1111", 4'b1111, 1'b0, 1'b0);
    d = 4'b0101; en = 1'b0;
    step();
    chk4("hold edge1", 4'b1111, 1'b0, 1'b0);
    step();
    chk4("hold edge2", 4'b1111, 1'b0, 1'b0);

    // Shift / rotate
    en = 1'b1; mode = 3'b001; d = 4'b1001;
    step();
    chk4("load 1001", 4'b1001, 1'b0, 1'b0);
    chk("sout 1001", {6'h0, sout_l, sout_r}, 8'h03);
    mode = 3'b010; sin_r = 1'b0;
    step();
    chk4("shl", 4'b0010, 1'b0, 1'b0);
    chk("sout shl", {6'h0, sout_l, sout_r}, 8'h00);
    mode = 3'b011; sin_l = 1'b1;
    step();
    chk4("shr", 4'b1001, 1'b0, 1'b0);
    mode = 3'b100;
    step();
    chk4("rol", 4'b0011, 1'b0, 1'b0);
    chk("sout rol", {6'h0, sout_l, sout_r}, 8'h01);
    mode = 3'b101;
    step();
    chk4("ror", 4'b1001, 1'b0, 1'b0);
    mode = 3'b010; sin_r = 1'b1;
    step();
    chk4("shl sin1", 4'b0011, 1'b0, 1'b0);

    // Count wrap up then down
    mode = 3'b001; d = 4'b1110;
    step();
    mode = 3'b110;
    step();
    chk4("inc 1111", 4'b1111, 1'b0, 1'b0);
    step();
    chk4("inc wrap", 4'b0000, 1'b1, 1'b1);
    step();
    chk4("inc 0001", 4'b0001, 1'b0, 1'b0);
    mode = 3'b111;
    step();
    chk4("dec 0000", 4'b0000, 1'b1, 1'b0);
    step();
    chk4("dec wrap", 4'b1111, 1'b0, 1'b1);

    // Clear overrides load and drops a pending carry
    clr = 1'b1; mode = 3'b001; d = 4'b1111;
    step();
    chk4("clr en1", 4'b0000, 1'b1, 1'b0);
    clr = 1'b0; d = 4'b0110;
    step();
    chk4("load 0110", 4'b0110, 1'b0, 1'b0);
    clr = 1'b1; en = 1'b0;
    step();
    chk4("clr en0", 4'b0000, 1'b1, 1'b0);
    clr = 1'b0;

    // Enable low kills carry; X mode holds
    en = 1'b1; mode = 3'b111;
    step();
    chk4("dec borrow", 4'b1111, 1'b0, 1'b1);
    en = 1'b0;
    step();
    chk4("en0 carry drop", 4'b1111, 1'b0, 1'b0);
    en = 1'b1; mode = 3'bxxx;
    step();
    chk4("x mode hold", 4'b1111, 1'b0, 1'b0);
    mode = 3'b000;
    step();
    chk4("hold mode", 4'b1111, 1'b0, 1'b0);

    // 8-bit instance: count up from FF
    en8 = 1'b1; mode8 = 3'b001; d8 = 8'hFF;
    step();
    chk("w8 load", q8, 8'hFF);
    mode8 = 3'b110;
    step();
    chk("w8 wrap q", q8, 8'h00);
    chk("w8 wrap carry", {7'h0, carry8}, 8'h01);
    chk("w8 zero", {7'h0, zero8}, 8'h01);
    step();
    chk("w8 q 01", q8, 8'h01);
    chk("w8 carry drop", {7'h0, carry8}, 8'h00);
    chk("w8 sout", {6'h0, sout_l8, sout_r8}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
